// File: rtl/bfly_addsub_seq.sv
// bfly_addsub_seq: sequences one shared FP adder/subtractor through the four
// operations of a radix-2 complex butterfly, y0 = a+b and y1 = a-b.
module bfly_addsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_re,
    input  logic [31:0] a_im,
    input  logic [31:0] b_re,
    input  logic [31:0] b_im,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ctrl,
    input  logic [31:0] add_ans,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y0_re,
    output logic [31:0] y0_im,
    output logic [31:0] y1_re,
    output logic [31:0] y1_im,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, OP0, OP1, OP2, OP3, DONE} state_t;
    state_t state_q, state_d;
    logic [31:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic [31:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
    logic accept;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? OP0 : IDLE;
            OP0:     state_d = OP1;
            OP1:     state_d = OP2;
            OP2:     state_d = OP3;
            OP3:     state_d = DONE;
            DONE:    state_d = !out_ready ? DONE : (in_valid ? OP0 : IDLE);
            default: state_d = IDLE;
        endcase
    end
    // Adder lines come only from registered state and captured operands.
    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
        accept    = in_valid && in_ready;
        add_a     = (state_q == OP0 || state_q == OP2) ? a_re_q :
                    (state_q == OP1 || state_q == OP3) ? a_im_q : '0;
        add_b     = (state_q == OP0 || state_q == OP2) ? b_re_q :
                    (state_q == OP1 || state_q == OP3) ? b_im_q : '0;
        add_ctrl  = state_q == OP2 || state_q == OP3;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            y0_re_q <= '0;
            y0_im_q <= '0;
            y1_re_q <= '0;
            y1_im_q <= '0;
        end else begin
            if (accept) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                b_re_q <= b_re;
                b_im_q <= b_im;
            end
            if (state_q == OP0) y0_re_q <= add_ans;
            if (state_q == OP1) y0_im_q <= add_ans;
            if (state_q == OP2) y1_re_q <= add_ans;
            if (state_q == OP3) y1_im_q <= add_ans;
        end
    end
    assign y0_re = y0_re_q;
    assign y0_im = y0_im_q;
    assign y1_re = y1_re_q;
    assign y1_im = y1_im_q;
endmodule

// File: tb/tb_bfly_addsub_seq.sv
// tb_bfly_addsub_seq: scoreboard bench for bfly_addsub_seq with a behavioural FP adder.
module tb_bfly_addsub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, add_ctrl, out_valid, out_ready, busy;
    logic [31:0] a_re, a_im, b_re, b_im, add_a, add_b, add_ans;
    logic [31:0] y0_re, y0_im, y1_re, y1_im;
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    int          hs_cnt = 0, hs_base = 0, last_hs = 0;
    bit          period_chk = 0, held = 0;
    logic [127:0] saved, sb[$];

    bfly_addsub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl), .add_ans(add_ans),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // single <-> double for normal numbers and zero; directed values are exact
    function automatic real f2d(logic [31:0] f);
        logic [10:0] e;
        e = {3'b000, f[30:23]} + 11'd896;
        return (f[30:23] == 8'd0) ? 0.0 : $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction
    function automatic logic [31:0] d2f(real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return (b[62:52] == 11'd0) ? 32'd0 : {b[63], e[7:0], b[51:29]};
    endfunction
    always_comb add_ans = d2f(add_ctrl ? f2d(add_a) - f2d(add_b) : f2d(add_a) + f2d(add_b));

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(logic [31:0] ar, ai, br, bi, logic [127:0] exp, bit push);
        int k = 0;
        @(posedge clk) #1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        if (push) sb.push_back(exp);
        @(posedge clk);
    endtask

    localparam logic [31:0] RA [4] = '{32'h3F800000, 32'h40800000, 32'h3F000000, 32'h40000000};
    localparam logic [31:0] IA [4] = '{32'h3F000000, 32'h3F800000, 32'hBF800000, 32'h40000000};
    localparam logic [31:0] RB [4] = '{32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3F000000};
    localparam logic [31:0] IB [4] = '{32'h3E800000, 32'h40400000, 32'h3F800000, 32'h3F000000};
    localparam logic [127:0] EXP [4] = '{
        {32'h40400000, 32'h3F400000, 32'hBF800000, 32'h3E800000},
        {32'h40A00000, 32'h40800000, 32'h40400000, 32'hC0000000},
        {32'h3F800000, 32'h00000000, 32'h00000000, 32'hC0000000},
        {32'h40200000, 32'h40200000, 32'h3FC00000, 32'h3FC00000}};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        fork
            begin : main_seq
                int seen;
                repeat (2) @(negedge clk);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_add", {add_a, add_b, add_ctrl}, 0);
                chk("rst_y", {y0_re, y0_im, y1_re, y1_im}, 0);
                @(posedge clk) #1 rst = 1'b0;
                // basic butterfly with adder sequencing
                issue(RA[0], IA[0], RB[0], IB[0], EXP[0], 1);
                #1 in_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk($sformatf("seq_add_a%0d", k), add_a, k[0] ? IA[0] : RA[0]);
                    chk($sformatf("seq_add_b%0d", k), add_b, k[0] ? IB[0] : RB[0]);
                    chk($sformatf("seq_ctrl%0d", k), add_ctrl, k >= 2);
                end
                @(negedge clk);
                chk("t5_out_valid", out_valid, 1);
                // input isolation: live operands corrupted from OP1 on
                issue(RA[0], IA[0], RB[0], IB[0], EXP[0], 1);
                #1 in_valid = 1'b0;
                @(posedge clk) #1;
                a_re = 32'h7F800000; a_im = 32'h41200000; b_re = 32'hC1200000; b_im = 32'h42000000;
                repeat (8) @(negedge clk);
                // backpressure
                out_ready = 1'b0;
                issue(RA[1], IA[1], RB[1], IB[1], EXP[1], 1);
                #1 in_valid = 1'b0;
                for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
                chk("bp_reach_done", out_valid, 1);
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk) #1;
                    a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
                    in_valid = k[0];
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                end
                @(posedge clk) #1;
                in_valid = 1'b0; out_ready = 1'b1;
                repeat (6) @(negedge clk);
                chk("bp_no_capture", {out_valid, busy}, 0);
                // back-to-back
                hs_base = hs_cnt; period_chk = 1;
                for (int s = 2; s < 5; s++)
                    issue(RA[s % 4], IA[s % 4], RB[s % 4], IB[s % 4], EXP[s % 4], 1);
                #1 in_valid = 1'b0;
                repeat (8) @(negedge clk);
                period_chk = 0;
                chk("b2b_count", hs_cnt - hs_base, 3);
                // reset mid-OP2
                issue(RA[3], IA[3], RB[3], IB[3], '0, 0);
                #1 in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 chk("pre_rst_ctrl", add_ctrl, 1);
                rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_in_ready", in_ready, 1);
                chk("mid_rst_flags", {out_valid, busy, add_ctrl}, 0);
                chk("mid_rst_y", {y0_re, y0_im, y1_re, y1_im}, 0);
                @(posedge clk) #1 rst = 1'b0;
                seen = 0;
                repeat (6) begin
                    @(negedge clk);
                    seen += int'(out_valid);
                end
                chk("mid_rst_no_valid", seen, 0);
                for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
                chk("sb_empty", sb.size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst && out_valid) begin
                        if (held) chk("hold_stable", {y0_re, y0_im, y1_re, y1_im}, saved);
                        if (out_ready) begin
                            hs_cnt++;
                            if (sb.size() == 0) begin
                                n_chk++;
                                n_fail++;
                                $display("FAIL unexpected_output: got %h expected none",
                                         {y0_re, y0_im, y1_re, y1_im});
                            end else chk("result", {y0_re, y0_im, y1_re, y1_im}, sb.pop_front());
                            if (period_chk && hs_cnt > hs_base + 1) chk("b2b_period", cyc - last_hs, 5);
                            last_hs = cyc;
                            held = 0;
                        end else begin
                            held = 1;
                            saved = {y0_re, y0_im, y1_re, y1_im};
                        end
                    end else held = 0;
                end
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bfly_addsub_seq.md
# bfly_addsub_seq

Sequencer that time-multiplexes one shared combinational single-precision floating-point adder/subtractor to compute a radix-2 complex butterfly sum/difference pair. It accepts a complex operand pair (a, b) and issues four adder operations, one per cycle: Re(a+b), Im(a+b), Re(a−b), Im(a−b). It then presents y0 = a+b and y1 = a−b on a valid/ready output. It sits between the FFT stage's operand fetch and the result write-back, and owns the adder's operand and control lines exclusively.

## Interface
- No parameters. Data width is fixed at 32 bits (IEEE-754 single).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a_re, a_im, b_re, b_im  in  32 each  operands, sampled on accept.
- add_a, add_b  out  32 each  operands driven to the shared adder.
- add_ctrl  out  1  adder control: 0 = add, 1 = subtract (a − b).
- add_ans  in  32  combinational adder result for the current add_a/add_b/add_ctrl.
- out_valid  out  1  y0/y1 valid.
- out_ready  in  1  consumer accepts y0/y1.
- y0_re, y0_im, y1_re, y1_im  out  32 each  registered results.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, OP0, OP1, OP2, OP3, DONE. Encoding is free.
- IDLE: in_ready = 1. On in_valid, capture a_re, a_im, b_re and b_im into internal registers and go to OP0.
- Each OPn state drives the adder from the captured registers only, never from the live inputs:
  - OP0: add_a = a_re, add_b = b_re, add_ctrl = 0. On the clock edge, y0_re ← add_ans. Next state OP1.
  - OP1: add_a = a_im, add_b = b_im, add_ctrl = 0. y0_im ← add_ans. Next state OP2.
  - OP2: add_a = a_re, add_b = b_re, add_ctrl = 1. y1_re ← add_ans. Next state OP3.
  - OP3: add_a = a_im, add_b = b_im, add_ctrl = 1. y1_im ← add_ans. Next state DONE.
- In IDLE and DONE, add_a, add_b and add_ctrl are 0.
- DONE: out_valid = 1. y0/y1 are held stable until out_ready.
  - out_ready = 0: stay in DONE.
  - out_ready = 1, in_valid = 0: go to IDLE.
  - out_ready = 1, in_valid = 1: accept the new pair in the same cycle and go to OP0 (back-to-back).
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- in_valid is ignored in OP0–OP3. The operand inputs may change freely while busy.
- The block does no arithmetic. Results are add_ans captured bit-exact, and the block does not interpret NaN, Inf or denormal values.
- Output result registers update only in their own OPn state. They keep their value after the handshake until overwritten.

## Timing
- Reset values (asynchronous, effective immediately):
  - State: IDLE.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0; add_a, add_b and add_ctrl are 0.
  - Registers: all y*, and all captured operand registers, are 0.
- Latency: accept on edge T; OP0 in cycle T+1 through OP3 in cycle T+4; out_valid high from cycle T+5.
- Throughput: one butterfly per 5 cycles with out_ready held high.
- add_a, add_b and add_ctrl are decoded from registered state and captured operands only, so they are glitch-free within the cycle. The adder path is add_* → add_ans → y* register, one cycle, combinational.
- Reset asserted mid-operation (OP0–DONE):
  - Abort immediately and return to IDLE.
  - Partial results are cleared to 0, and no out_valid is produced.
- out_valid and the y* values must not change while out_valid = 1 and out_ready = 0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-OP2.
  - Required response: next cycle in_ready = 1, out_valid = 0, busy = 0, all y* = 0, add_ctrl = 0.
- Basic butterfly, using an IEEE-correct behavioural adder model:
  - Stimulus: a = (0x3F800000, 0x3F000000) = (1.0, 0.5); b = (0x40000000, 0x3E800000) = (2.0, 0.25).
  - Required response at T+5: y0 = (0x40400000, 0x3F400000); y1 = (0xBF800000, 0x3E800000).
- Adder sequencing:
  - Stimulus: the basic-butterfly operands.
  - Required response: add_ctrl = 0, 0, 1, 1 in cycles T+1 to T+4; add_a alternates a_re, a_im, a_re, a_im; add_b alternates b_re, b_im, b_re, b_im.
- Output backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE, and toggle the a/b inputs and in_valid meanwhile.
  - Required response: y* stable, in_ready = 0, no new capture; results released once out_ready = 1.
- Back-to-back:
  - Stimulus: in_valid = 1 and out_ready = 1 continuously with 3 distinct operand sets.
  - Required response: out_valid pulses exactly every 5 cycles, each result matches its own operand set, no set is dropped or duplicated.
- Input isolation:
  - Stimulus: change a_re to 0x7F800000 during OP1.
  - Required response: y1_re still uses the captured a_re; result unchanged versus the stable-input run.
